dac_serializer: RTL
===================

Name: dac_serializer

Overview:
- Output stage downstream of the L/R MAC filters. Accepts one filtered stereo sample pair per audio frame over a valid/ready handshake.
- Double-buffers the pair and shifts it out MSB-first on the codec DAC data line, framed by the codec's DAC LR clock.
- Runs entirely in the bit-clock domain; the codec bit clock drives clk.
- Replaces the direct DAC data wiring in the top level.

Parameters:
- WORD_LENGTH, 16: bits per channel sample; equals the filter output width.
- SLOT_BITS, 32: maximum bit-clock cycles per LRCK half-frame; sets the bit-counter width to clog2(SLOT_BITS+1).
- UNDERRUN_WIDTH, 8: width of the saturating underrun counter.

Ports:
- clk  input  1  bit clock (AUD_BCLK); all logic on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- lrck  input  1  DAC LR clock; low selects left, high selects right.
- data_L  input  WORD_LENGTH  left sample, two's complement.
- data_R  input  WORD_LENGTH  right sample, two's complement.
- data_valid  input  1  sample pair present.
- data_ready  output  1  pair accepted on a cycle where valid and ready are both high.
- serial_out  output  1  serial DAC data (AUD_DACDAT).
- frame_start  output  1  one-cycle pulse when a left word starts shifting.
- underrun_count  output  UNDERRUN_WIDTH  count of frames started with no pending pair; saturates.

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low.
- Reset values:
  - serial_out=0, frame_start=0, underrun_count=0, data_ready=1.
  - Pending buffer empty; active L/R registers 0; lrck_q=0; state IDLE.
- Edge detection:
  - lrck_q registers lrck every cycle.
  - Falling edge: lrck_q=1 and lrck=0. Rising edge: lrck_q=0 and lrck=1.
- Pending buffer: one entry (pend_L, pend_R, pend_full).
  - data_ready = ~pend_full | xfer.
  - xfer = falling edge detected and pend_full.
  - If a handshake and xfer happen in the same cycle, the new pair lands in the buffer and pend_full stays 1.
- At every falling edge:
  - If pend_full: active_L/active_R <= pend_L/pend_R and pend_full is cleared, unless refilled in the same cycle.
  - Else: active_L/active_R <= 0 and underrun_count increments, saturating at all-ones.
  - The first falling edge after reset also counts as an underrun if the buffer is empty.
- States:
  - IDLE: serial_out=0; on a falling edge go to SHIFT_L. Rising edges are ignored in IDLE.
  - SHIFT_L: shift register loaded with the new active_L; outputs WORD_LENGTH bits MSB-first, one per cycle; then go to PAD_L.
  - PAD_L: serial_out=0; on a rising edge go to SHIFT_R.
  - SHIFT_R: loaded with active_R; outputs WORD_LENGTH bits; then go to PAD_R.
  - PAD_R: serial_out=0; on a falling edge go to SHIFT_L.
- Latency: the MSB appears on serial_out in the first cycle after the edge-detect cycle. frame_start pulses in that same cycle, left only.
- Edge inside SHIFT (half-frame shorter than WORD_LENGTH): the current word is truncated and the new channel starts immediately on the matching edge.
- Wrong-polarity edge while shifting (e.g. a falling edge in SHIFT_R): abort to SHIFT_L with normal load/underrun handling.
- Bit counter:
  - Counts cycles since the edge, up to SLOT_BITS, then holds.
  - More than SLOT_BITS cycles without an edge: go to IDLE and hold serial_out=0.
- Reset mid-frame: all state clears asynchronously. Serialization resumes only from the next falling edge.

Optional Feature:
- Macro: DAC_SERIALIZER_I2S_DELAY_EN.
- Defined (I2S): one extra cycle of serial_out=0 after the edge-detect cycle. The MSB appears two cycles after the edge-detect cycle; frame_start still pulses one cycle after it. Word end and PAD entry shift one cycle later.
- Undefined: left-justified timing as described in Behaviour.

Test Plan:
- WORD_LENGTH=16, 32-cycle half frames; push L=16'hA5C3, R=16'h3C5A before the first falling edge -> after the falling edge, serial_out = 1010010111000011 then 16 zeros; after the rising edge, 0011110001011010 then zeros; frame_start pulses once; underrun_count=0.
- No data pushed; three frames -> serial_out constantly 0, underrun_count=3. Separately, force 300 underruns -> count saturates at 255.
- Pair pushed with pend_full=1 in the same cycle as a falling edge -> data_ready=1, the old pair goes active, the new pair stays pending, no pair is lost across the following 2 frames.
- Half-frame of 10 cycles with L=16'hFFFF -> exactly 10 ones output, then the right word starts on the rising edge.
- Assert reset in the middle of SHIFT_R -> serial_out=0 immediately, underrun_count=0; serialization restarts only at the next falling edge.
- DAC_SERIALIZER_I2S_DELAY_EN defined, L=16'h8001 -> one 0 cycle, then 1000000000000001, then zeros.

Source files
------------

// File: rtl/dac_serializer.sv
// dac_serializer
//   Output stage after the L/R MAC filters. Takes one stereo pair per audio
//   frame over valid/ready, holds it in a one-entry pending buffer, and shifts
//   it MSB-first onto the codec DAC data line, framed by the DAC LR clock.
//   Everything runs on the codec bit clock.
//
//   Build option: DAC_SERIALIZER_I2S_DELAY_EN
//     defined   - I2S timing: one extra zero bit after each LRCK edge.
//     undefined - left-justified timing: MSB immediately after edge detect.
//
// Ports
//   clk            bit clock (AUD_BCLK), rising edge
//   reset          asynchronous, active-low
//   lrck           DAC LR clock, low = left, high = right
//   data_L/data_R  two's complement samples
//   data_valid     sample pair present
//   data_ready     pair taken when valid & ready
//   serial_out     AUD_DACDAT
//   frame_start    one-cycle pulse as a left word starts
//   underrun_count saturating count of frames started with nothing pending
module dac_serializer #(
    parameter int WORD_LENGTH    = 16,
    parameter int SLOT_BITS      = 32,
    parameter int UNDERRUN_WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      lrck,
    input  logic [WORD_LENGTH-1:0]    data_L,
    input  logic [WORD_LENGTH-1:0]    data_R,
    input  logic                      data_valid,
    output logic                      data_ready,
    output logic                      serial_out,
    output logic                      frame_start,
    output logic [UNDERRUN_WIDTH-1:0] underrun_count
);

`ifdef DAC_SERIALIZER_I2S_DELAY_EN
    localparam int LEAD = 1;
`else
    localparam int LEAD = 0;
`endif

    localparam int                CNT_W    = $clog2(SLOT_BITS + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(SLOT_BITS);
    localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(WORD_LENGTH - 1 + LEAD);

    typedef enum logic [2:0] {IDLE, SHIFT_L, PAD_L, SHIFT_R, PAD_R} state_t;

    state_t                 state, state_nxt;
    logic                   lrck_q;
    logic                   fall, rise;
    logic [WORD_LENGTH-1:0] pend_L, pend_R;
    logic                   pend_full;
    logic                   xfer, accept;
    logic [WORD_LENGTH-1:0] active_R;
    logic [WORD_LENGTH-1:0] new_L;
    logic [WORD_LENGTH-1:0] shreg;
    logic [CNT_W-1:0]       bit_cnt;
    logic                   load_l, load_r;
    logic                   shifting;
    logic                   lead_done;

    assign fall       = lrck_q & ~lrck;
    assign rise       = ~lrck_q & lrck;
    assign xfer       = fall & pend_full;
    assign data_ready = ~pend_full | xfer;
    assign accept     = data_valid & data_ready;

    // Word entering the left slot: the pending pair, or silence on underrun.
    assign new_L      = pend_full ? pend_L : '0;

    assign shifting   = (state == SHIFT_L) || (state == SHIFT_R);

`ifdef DAC_SERIALIZER_I2S_DELAY_EN
    // First cycle after the edge is the I2S one-bit delay slot.
    assign lead_done  = (bit_cnt != '0);
`else
    assign lead_done  = 1'b1;
`endif

    assign serial_out = shifting & lead_done & shreg[WORD_LENGTH-1];

    // Any falling edge restarts the left word, even mid-word or from the
    // right half (wrong-polarity abort). A rising edge only starts the right
    // word once a left half is underway, so IDLE ignores it.
    always_comb begin
        state_nxt = state;
        load_l    = 1'b0;
        load_r    = 1'b0;
        if (fall) begin
            state_nxt = SHIFT_L;
            load_l    = 1'b1;
        end else if (rise && (state == SHIFT_L || state == PAD_L)) begin
            state_nxt = SHIFT_R;
            load_r    = 1'b1;
        end else if (state != IDLE && bit_cnt == CNT_MAX) begin
            // LRCK stalled: go quiet until the next falling edge.
            state_nxt = IDLE;
        end else begin
            case (state)
                SHIFT_L: if (bit_cnt == LAST_BIT) state_nxt = PAD_L;
                SHIFT_R: if (bit_cnt == LAST_BIT) state_nxt = PAD_R;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lrck_q         <= 1'b0;
            frame_start    <= 1'b0;
            pend_L         <= '0;
            pend_R         <= '0;
            pend_full      <= 1'b0;
            active_R       <= '0;
            underrun_count <= '0;
            shreg          <= '0;
            bit_cnt        <= '0;
        end else begin
            lrck_q      <= lrck;
            frame_start <= fall;

            // A refill in the transfer cycle wins, keeping the buffer full.
            if (accept) begin
                pend_L    <= data_L;
                pend_R    <= data_R;
                pend_full <= 1'b1;
            end else if (xfer) begin
                pend_full <= 1'b0;
            end

            // The left word goes straight into the shift register; only the
            // right word needs to wait for its half-frame.
            if (fall) begin
                active_R <= pend_full ? pend_R : '0;
                if (!pend_full && underrun_count != '1)
                    underrun_count <= underrun_count + 1'b1;
            end

            if (load_l || load_r)        bit_cnt <= '0;
            else if (bit_cnt != CNT_MAX) bit_cnt <= bit_cnt + 1'b1;

            if (load_l)                     shreg <= new_L;
            else if (load_r)                shreg <= active_R;
            else if (shifting && lead_done) shreg <= {shreg[WORD_LENGTH-2:0], 1'b0};
        end
    end

endmodule
